// File: rtl/sync_frame_deserializer.sv
// sync_frame_deserializer
// Hunts for a programmable sync word in a serial bitstream, confirms
// alignment over LOCK_CNT consecutive frames, then emits DATA_W-bit payload
// words. Lock is dropped after LOSS_CNT consecutive sync misses.
//
// Ports:
//   t_clk        bit clock, rising edge
//   rst_n        asynchronous active-low reset
//   en           bit-sample enable
//   data_in      serial data, MSB of each field first
//   data_out     last payload word (held between strobes)
//   data_valid   one-cycle pulse, data_out updated
//   frame_start  one-cycle pulse with the first word of a frame
//   locked       high while in LOCKED
//   sync_err     one-cycle pulse on a sync miss while LOCKED
//
// state  | meaning
// HUNT   | search every enabled bit for the sync pattern
// VERIFY | candidate alignment found, confirm at each frame check point
// LOCKED | aligned, emit payload words, count sync misses
module sync_frame_deserializer #(
   parameter int          DATA_W        = 8,
   parameter int          SYNC_W        = 8,
   parameter logic [SYNC_W-1:0] SYNC_PAT = 8'hA5,
   parameter int          PAYLOAD_WORDS = 4,
   parameter int          LOCK_CNT      = 2,
   parameter int          LOSS_CNT      = 2
) (
   input  logic              t_clk,
   input  logic              rst_n,
   input  logic              en,
   input  logic              data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_valid,
   output logic              frame_start,
   output logic              locked,
   output logic              sync_err
);

   localparam int SR_W     = (SYNC_W > DATA_W) ? SYNC_W : DATA_W;
   localparam int PAY_BITS = PAYLOAD_WORDS * DATA_W;
   localparam int F        = SYNC_W + PAY_BITS;
   localparam int POS_W    = $clog2(F);
   localparam int WB_W     = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam int GC_W     = $clog2(LOCK_CNT + 1);
   localparam int MC_W     = $clog2(LOSS_CNT + 1);

   localparam logic [POS_W-1:0] POS_LAST  = POS_W'(F - 1);
   localparam logic [POS_W-1:0] POS_PAY   = POS_W'(PAY_BITS);
   localparam logic [POS_W-1:0] POS_FIRST = POS_W'(DATA_W - 1);
   localparam logic [WB_W-1:0]  WB_LAST   = WB_W'(DATA_W - 1);
   localparam logic [GC_W-1:0]  GC_ONE    = GC_W'(1);
   localparam logic [GC_W-1:0]  GC_MAX    = GC_W'(LOCK_CNT);
   localparam logic [MC_W-1:0]  MC_ONE    = MC_W'(1);
   localparam logic [MC_W-1:0]  MC_MAX    = MC_W'(LOSS_CNT);

   typedef enum logic [1:0] {HUNT, VERIFY, LOCKED} state_t;

   state_t            state;
   logic [SR_W-1:0]   sr;
   logic [SR_W-1:0]   shifted;
   logic [POS_W-1:0]  pos;
   logic [POS_W-1:0]  pos_nxt;
   logic [WB_W-1:0]   wbit;
   logic [WB_W-1:0]   wbit_nxt;
   logic [GC_W-1:0]   good_cnt;
   logic [MC_W-1:0]   miss_cnt;
   logic              match;
   logic              at_check;
   logic              in_payload;
   logic              word_end;

   // wbit tracks the bit index inside the current payload word so word ends
   // are found without a modulo on pos; it idles at 0 during the sync field.
   always_comb begin
      shifted    = {sr[SR_W-2:0], data_in};
      match      = (shifted[SYNC_W-1:0] == SYNC_PAT);
      at_check   = (pos == POS_LAST);
      in_payload = (pos < POS_PAY);
      word_end   = in_payload && (wbit == WB_LAST);
      pos_nxt    = at_check ? '0 : pos + POS_W'(1);
      wbit_nxt   = wbit;
      if (at_check || word_end) begin
         wbit_nxt = '0;
      end else if (in_payload) begin
         wbit_nxt = wbit + WB_W'(1);
      end
   end

   always_ff @(posedge t_clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= HUNT;
         sr          <= '0;
         pos         <= '0;
         wbit        <= '0;
         good_cnt    <= '0;
         miss_cnt    <= '0;
         data_out    <= '0;
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         locked      <= 1'b0;
         sync_err    <= 1'b0;
      end else begin
         data_valid  <= 1'b0;
         frame_start <= 1'b0;
         sync_err    <= 1'b0;
         if (en) begin
            sr <= shifted;
            unique case (state)
               HUNT: begin
                  if (match) begin
                     pos      <= '0;
                     wbit     <= '0;
                     good_cnt <= GC_ONE;
                     miss_cnt <= '0;
                     if (LOCK_CNT == 1) begin
                        state  <= LOCKED;
                        locked <= 1'b1;
                     end else begin
                        state <= VERIFY;
                     end
                  end
               end
               VERIFY: begin
                  pos  <= pos_nxt;
                  wbit <= wbit_nxt;
                  if (at_check) begin
                     if (!match) begin
                        state    <= HUNT;
                        good_cnt <= '0;
                     end else if (good_cnt + GC_ONE == GC_MAX) begin
                        state    <= LOCKED;
                        locked   <= 1'b1;
                        good_cnt <= '0;
                        miss_cnt <= '0;
                     end else begin
                        good_cnt <= good_cnt + GC_ONE;
                     end
                  end
               end
               LOCKED: begin
                  pos  <= pos_nxt;
                  wbit <= wbit_nxt;
                  if (word_end) begin
                     data_out    <= shifted[DATA_W-1:0];
                     data_valid  <= 1'b1;
                     frame_start <= (pos == POS_FIRST);
                  end
                  if (at_check) begin
                     if (match) begin
                        miss_cnt <= '0;
                     end else begin
                        sync_err <= 1'b1;
                        if (miss_cnt + MC_ONE == MC_MAX) begin
                           state    <= HUNT;
                           locked   <= 1'b0;
                           miss_cnt <= '0;
                        end else begin
                           miss_cnt <= miss_cnt + MC_ONE;
                        end
                     end
                  end
               end
               default: begin
                  state  <= HUNT;
                  locked <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_sync_frame_deserializer.sv
module tb_sync_frame_deserializer;

   logic       t_clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       data_in = 1'b0;
   logic [7:0] data_out;
   logic       data_valid;
   logic       frame_start;
   logic       locked;
   logic       sync_err;

   sync_frame_deserializer dut (
      .t_clk       (t_clk),
      .rst_n       (rst_n),
      .en          (en),
      .data_in     (data_in),
      .data_out    (data_out),
      .data_valid  (data_valid),
      .frame_start (frame_start),
      .locked      (locked),
      .sync_err    (sync_err)
   );

   always #5 t_clk = ~t_clk;

   int n_chk = 0;
   int n_err = 0;

   // per-frame observations
   int          f_nv, f_fs, f_fs_first, f_err, f_conflict, en0_pulses;
   logic [31:0] f_words;
   bit          lk6, lk7, lke, any_locked;

   typedef struct {
      logic [7:0]  sync;
      logic [31:0] pay;
      int          nv;
      logic [31:0] words;
      int          nerr;
      bit          lk6;
      bit          lk7;
      bit          lke;
   } vec_t;

   vec_t tbl[9];

   task automatic chk(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_err++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic clear_obs();
      f_nv = 0; f_fs = 0; f_fs_first = 0; f_err = 0; f_conflict = 0;
      f_words = '0; any_locked = 0;
   endtask

   task automatic send_bit(input logic b, input bit tog);
      @(negedge t_clk);
      data_in = b;
      en      = 1'b1;
      @(posedge t_clk);
      #1;
      if (data_valid) begin
         if (frame_start && f_nv == 0) f_fs_first++;
         f_nv++;
         f_words = {f_words[23:0], data_out};
      end
      if (frame_start) f_fs++;
      if (sync_err) f_err++;
      if (data_valid && sync_err) f_conflict++;
      if (locked) any_locked = 1;
      if (tog) begin
         @(negedge t_clk);
         en = 1'b0;
         @(posedge t_clk);
         #1;
         if (data_valid || frame_start || sync_err) en0_pulses++;
      end
   endtask

   task automatic send_frame(input logic [7:0] s, input logic [31:0] p, input bit tog);
      logic [39:0] fr;
      fr = {s, p};
      clear_obs();
      for (int j = 0; j < 40; j++) begin
         send_bit(fr[39-j], tog);
         if (j == 6) lk6 = locked;
         if (j == 7) lk7 = locked;
      end
      lke = locked;
   endtask

   task automatic do_reset();
      @(negedge t_clk);
      rst_n = 1'b0; en = 1'b0; data_in = 1'b0;
      repeat (2) @(posedge t_clk);
      @(negedge t_clk);
      rst_n = 1'b1;
   endtask

   initial begin
      logic [79:0] noise;

      tbl[0] = '{8'hA5, 32'h11223344, 0, 32'h0,        0, 0, 0, 0};
      tbl[1] = '{8'hA5, 32'h11223344, 4, 32'h11223344, 0, 0, 1, 1};
      tbl[2] = '{8'hA5, 32'h55667788, 4, 32'h55667788, 0, 1, 1, 1};
      tbl[3] = '{8'hA4, 32'h99AABBCC, 4, 32'h99AABBCC, 1, 1, 1, 1};
      tbl[4] = '{8'hA5, 32'h01020304, 4, 32'h01020304, 0, 1, 1, 1};
      tbl[5] = '{8'hA4, 32'hDEADBEEF, 4, 32'hDEADBEEF, 1, 1, 1, 1};
      tbl[6] = '{8'hA4, 32'h00000000, 0, 32'h0,        1, 1, 0, 0};
      tbl[7] = '{8'hA5, 32'h12345678, 0, 32'h0,        0, 0, 0, 0};
      tbl[8] = '{8'hA5, 32'h9ABCDEF0, 4, 32'h9ABCDEF0, 0, 0, 1, 1};

      // reset state
      rst_n = 1'b0;
      #12;
      chk("reset_data_out", int'(data_out), 0);
      chk("reset_pulses", int'({data_valid, frame_start, sync_err}), 0);
      chk("reset_locked", int'(locked), 0);
      do_reset();

      // frame sequence: lock, single miss, recovery, double miss, re-lock
      for (int i = 0; i < 9; i++) begin
         send_frame(tbl[i].sync, tbl[i].pay, 1'b0);
         chk($sformatf("f%0d_nvalid", i), f_nv, tbl[i].nv);
         chk($sformatf("f%0d_words", i), int'(f_words), int'(tbl[i].words));
         chk($sformatf("f%0d_frame_start", i), f_fs, (tbl[i].nv > 0) ? 1 : 0);
         chk($sformatf("f%0d_fs_first", i), f_fs_first, f_fs);
         chk($sformatf("f%0d_sync_err", i), f_err, tbl[i].nerr);
         chk($sformatf("f%0d_conflict", i), f_conflict, 0);
         chk($sformatf("f%0d_locked_b6", i), int'(lk6), int'(tbl[i].lk6));
         chk($sformatf("f%0d_locked_b7", i), int'(lk7), int'(tbl[i].lk7));
         chk($sformatf("f%0d_locked_end", i), int'(lke), int'(tbl[i].lke));
      end

      // async reset mid-payload while locked
      clear_obs();
      for (int j = 0; j < 10; j++) send_bit((j < 8) ? tbl[0].sync[7-j] : 1'b0, 1'b0);
      chk("pre_rst_locked", int'(locked), 1);
      #2 rst_n = 1'b0;
      #1;
      chk("midrst_data_out", int'(data_out), 0);
      chk("midrst_locked", int'(locked), 0);
      chk("midrst_pulses", int'({data_valid, frame_start, sync_err}), 0);
      @(negedge t_clk);
      en = 1'b0;
      @(negedge t_clk);
      rst_n = 1'b1;
      send_frame(8'hA5, 32'h11223344, 1'b0);
      chk("rst_relock1_locked", int'(any_locked), 0);
      chk("rst_relock1_nvalid", f_nv, 0);
      send_frame(8'hA5, 32'h55667788, 1'b0);
      chk("rst_relock2_b7", int'(lk7), 1);
      chk("rst_relock2_words", int'(f_words), 32'h55667788);

      // noise with a false sync, then a bad check point
      do_reset();
      clear_obs();
      noise = {16'h3C0F, 8'hA5, 32'hFFFFFFFF, 8'h00, 16'h0000};
      for (int j = 0; j < 80; j++) send_bit(noise[79-j], 1'b0);
      chk("noise_locked", int'(any_locked), 0);
      chk("noise_nvalid", f_nv, 0);
      chk("noise_sync_err", f_err, 0);
      send_frame(8'hA5, 32'h11223344, 1'b0);
      chk("noise_hunt1_locked", int'(any_locked), 0);
      send_frame(8'hA5, 32'h55667788, 1'b0);
      chk("noise_hunt2_b6", int'(lk6), 0);
      chk("noise_hunt2_b7", int'(lk7), 1);
      chk("noise_hunt2_words", int'(f_words), 32'h55667788);

      // enable toggling every other cycle
      do_reset();
      en0_pulses = 0;
      send_frame(8'hA5, 32'h11223344, 1'b1);
      chk("tog_f0_nvalid", f_nv, 0);
      chk("tog_f0_locked", int'(lke), 0);
      send_frame(8'hA5, 32'h55667788, 1'b1);
      chk("tog_f1_b6", int'(lk6), 0);
      chk("tog_f1_b7", int'(lk7), 1);
      chk("tog_f1_nvalid", f_nv, 4);
      chk("tog_f1_words", int'(f_words), 32'h55667788);
      chk("tog_f1_fs_first", f_fs_first, 1);
      chk("tog_en0_pulses", en0_pulses, 0);

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule
